// File: rtl/test_end_monitor.sv
// test_end_monitor: end-of-test monitor for the alioth simulation SoC.
// Watches the core PC against NUM_CH watch addresses. Each entry of the PC
// onto an enabled watch address counts once. The test ends when any channel
// reaches HIT_THRESH entries (DONE), or optionally on a cycle timeout.
// Optional feature macro: TEST_MON_TIMEOUT_EN builds the timeout path and
// the TIMEOUT state; without it timeout_o is tied to 0.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pc_i          : current core PC
//   result_i      : result register, latched at the end event
//   watch_addr_i  : channel k address at bits [32k+31:32k]
//   watch_en_i    : per-channel enable
//   clear_i       : synchronous restart to RUN
//   done_o/pass_o/timeout_o/hit_ch_o/result_o : end status
//   cycle_cnt_o   : RUN cycles since reset/clear (saturating)
//   end_cycle_o/first_hit_o : cycle count at the first hit, and its valid
module test_end_monitor #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned HIT_THRESH   = 8,
  parameter int unsigned TIMEOUT_LOG2 = 20,
  parameter logic [31:0] PASS_VAL     = 32'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              result_i,
  input  logic [32*NUM_CH-1:0]     watch_addr_i,
  input  logic [NUM_CH-1:0]        watch_en_i,
  input  logic                     clear_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [2:0]               hit_ch_o,
  output logic [31:0]              result_o,
  output logic [31:0]              cycle_cnt_o,
  output logic [31:0]              end_cycle_o,
  output logic                     first_hit_o
);

  localparam int unsigned CW = 8;
  localparam int unsigned HW = 3;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
`ifdef TEST_MON_TIMEOUT_EN
    ST_TIMEOUT = 2'd2,
`endif
    ST_DONE    = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   last_pc_q, last_pc_d;
  logic [DW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [DW-1:0]   end_cycle_q, end_cycle_d;
  logic [DW-1:0]   result_q, result_d;
  logic [HW-1:0]   hit_ch_q, hit_ch_d;
  logic            first_hit_q, first_hit_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q [NUM_CH];
  logic [CW-1:0]   cnt_d [NUM_CH];

  logic [NUM_CH-1:0] hit_vec;
  logic [NUM_CH-1:0] reach_vec;
  logic [HW-1:0]     reach_ch;
  logic              timeout_fire;

  // Timeout condition from the registered cycle count.
`ifdef TEST_MON_TIMEOUT_EN
  assign timeout_fire = cycle_cnt_q[TIMEOUT_LOG2];
`else
  // Timeout not built; the term is constant 0 but keeps the parameter referenced.
  assign timeout_fire = 1'b0 & cycle_cnt_q[TIMEOUT_LOG2];
`endif

  // Hit detection, per-channel counting and lowest reaching channel.
  always_comb begin
    hit_vec   = '0;
    reach_vec = '0;
    reach_ch  = '0;
    cnt_d     = cnt_q;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      hit_vec[k] = (state_q == ST_RUN) && watch_en_i[k] &&
                   (pc_i == watch_addr_i[32*k +: 32]) && (pc_i != last_pc_q);
      if (hit_vec[k] && (cnt_q[k] != CW'(HIT_THRESH))) begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
      reach_vec[k] = hit_vec[k] && (cnt_d[k] == CW'(HIT_THRESH));
    end
    // Descending scan so the lowest reaching index is the one left standing.
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (reach_vec[k]) begin
        reach_ch = HW'(k);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_pc_d   = last_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    end_cycle_d = end_cycle_q;
    result_d    = result_q;
    hit_ch_d    = hit_ch_q;
    first_hit_d = first_hit_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    if (state_q == ST_RUN) begin
      last_pc_d = pc_i;
      if ((|hit_vec) && !first_hit_q) begin
        end_cycle_d = cycle_cnt_q;
        first_hit_d = 1'b1;
      end
      // The count holds on the edge entering TIMEOUT so it freezes at 2^LOG2.
      if ((cycle_cnt_q != '1) && !(timeout_fire && !(|reach_vec))) begin
        cycle_cnt_d = cycle_cnt_q + DW'(1);
      end
      if (|reach_vec) begin
        state_d  = ST_DONE;
        done_d   = 1'b1;
        result_d = result_i;
        pass_d   = (result_i == PASS_VAL);
        hit_ch_d = reach_ch;
      end
`ifdef TEST_MON_TIMEOUT_EN
      else if (timeout_fire) begin
        state_d   = ST_TIMEOUT;
        timeout_d = 1'b1;
        result_d  = result_i;
      end
`endif
    end

    if (clear_i) begin
      state_d     = ST_RUN;
      last_pc_d   = '0;
      cycle_cnt_d = '0;
      end_cycle_d = '0;
      result_d    = '0;
      hit_ch_d    = '0;
      first_hit_d = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  // Hit counters freeze outside RUN and zero on clear.
  logic [CW-1:0] cnt_nx [NUM_CH];
  always_comb begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      cnt_nx[k] = clear_i ? '0 : cnt_d[k];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      last_pc_q   <= '0;
      cycle_cnt_q <= '0;
      end_cycle_q <= '0;
      result_q    <= '0;
      hit_ch_q    <= '0;
      first_hit_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      last_pc_q   <= last_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      end_cycle_q <= end_cycle_d;
      result_q    <= result_d;
      hit_ch_q    <= hit_ch_d;
      first_hit_q <= first_hit_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        cnt_q[k] <= cnt_nx[k];
      end
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign hit_ch_o    = hit_ch_q;
  assign result_o    = result_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign end_cycle_o = end_cycle_q;
  assign first_hit_o = first_hit_q;

endmodule

// File: tb/tb_test_end_monitor.sv
// Bench for test_end_monitor: directed stimulus, a cycle model compared on
// every falling edge, and literal expectations at key points.
module tb_test_end_monitor;

  localparam int unsigned TH = 8;
  localparam int unsigned TL = 6;
`ifdef TEST_MON_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] result_i = '0;
  logic [63:0] watch_addr_i = '0;
  logic [1:0]  watch_en_i = '0;
  logic        clear_i = 1'b0;
  logic        done_o, pass_o, timeout_o, first_hit_o;
  logic [2:0]  hit_ch_o;
  logic [31:0] result_o, cycle_cnt_o, end_cycle_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  test_end_monitor #(
    .NUM_CH(2), .HIT_THRESH(TH), .TIMEOUT_LOG2(TL), .PASS_VAL(32'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .result_i(result_i),
    .watch_addr_i(watch_addr_i), .watch_en_i(watch_en_i), .clear_i(clear_i),
    .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .hit_ch_o(hit_ch_o), .result_o(result_o), .cycle_cnt_o(cycle_cnt_o),
    .end_cycle_o(end_cycle_o), .first_hit_o(first_hit_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: test-level status updated once per clock edge.
  int unsigned m_cnt [2];
  logic [31:0] m_last, m_cyc, m_end, m_res;
  bit          m_first, m_done, m_tmo, m_pass;
  int          m_ch;

  task automatic model_clear();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_last = 0; m_cyc = 0; m_end = 0; m_res = 0;
    m_first = 0; m_done = 0; m_tmo = 0; m_pass = 0; m_ch = 0;
  endtask

  task automatic model_step();
    int unsigned n [2];
    int win;
    bit any, hit, tmo;
    if (!rst_n || clear_i) begin
      model_clear();
    end else if (!m_done && !m_tmo) begin
      win = -1;
      any = 0;
      for (int k = 0; k < 2; k++) begin
        hit = watch_en_i[k] && (pc_i == watch_addr_i[32*k +: 32]) && (pc_i != m_last);
        n[k] = m_cnt[k] + (hit ? 1 : 0);
        if (n[k] > TH) n[k] = TH;
        if (hit) any = 1;
        if (hit && n[k] == TH && win < 0) win = k;
      end
      tmo = TMO_EN && (m_cyc >= (32'd1 << TL));
      if (any && !m_first) begin
        m_end = m_cyc;
        m_first = 1;
      end
      if (win >= 0) begin
        m_done = 1; m_res = result_i; m_pass = (result_i == 32'd1); m_ch = win;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      end else if (tmo) begin
        m_tmo = 1; m_res = result_i;
      end else if (m_cyc != 32'hFFFF_FFFF) begin
        m_cyc = m_cyc + 1;
      end
      m_cnt[0] = n[0]; m_cnt[1] = n[1];
      m_last = pc_i;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_done", 32'(done_o), 32'(m_done));
        chk("m_pass", 32'(pass_o), 32'(m_pass));
        chk("m_timeout", 32'(timeout_o), 32'(m_tmo));
        chk("m_hit_ch", 32'(hit_ch_o), 32'(m_ch));
        chk("m_result", result_o, m_res);
        chk("m_cycle", cycle_cnt_o, m_cyc);
        chk("m_end_cycle", end_cycle_o, m_end);
        chk("m_first", 32'(first_hit_o), 32'(m_first));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n entries onto 0xA0, each preceded by one cycle away on 0x9C.
  task automatic entries(input int n);
    for (int i = 0; i < n; i++) begin
      pc_i = 32'h9C; step(1);
      pc_i = 32'hA0; step(1);
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1; step(1);
    clear_i = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_cycle", cycle_cnt_o, 0);
    chk("rst_first", 32'(first_hit_o), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Pass: 8 entries on channel 0, result 1.
    watch_addr_i = {32'h0, 32'hA0};
    watch_en_i = 2'b01;
    result_i = 32'd1;
    entries(7);
    chk("t1_not_yet", 32'(done_o), 0);
    entries(1);
    chk("t1_done", 32'(done_o), 1);
    chk("t1_pass", 32'(pass_o), 1);
    chk("t1_ch", 32'(hit_ch_o), 0);
    chk("t1_end", end_cycle_o, 1);
    chk("t1_cycle", cycle_cnt_o, 16);
    step(3);
    chk("t1_frozen", cycle_cnt_o, 16);

    // Clear in DONE, then fail result.
    do_clear();
    chk("clr_cycle", cycle_cnt_o, 0);
    chk("clr_done", 32'(done_o), 0);
    result_i = 32'd5;
    entries(8);
    chk("t2_done", 32'(done_o), 1);
    chk("t2_pass", 32'(pass_o), 0);
    chk("t2_result", result_o, 5);

    // Held PC counts once.
    do_clear();
    pc_i = 32'hA0; step(20);
    pc_i = 32'h9C; step(1);
    chk("t3_held_done", 32'(done_o), 0);
    chk("t3_end", end_cycle_o, 0);
    entries(6);
    chk("t3_seven", 32'(done_o), 0);
    entries(1);
    chk("t3_done", 32'(done_o), 1);

    // Both channels on the same address: lowest index wins.
    watch_addr_i = {32'hA0, 32'hA0};
    watch_en_i = 2'b11;
    do_clear();
    entries(8);
    chk("t4_done", 32'(done_o), 1);
    chk("t4_ch", 32'(hit_ch_o), 0);

    // Only channel 1 enabled.
    watch_en_i = 2'b10;
    do_clear();
    entries(8);
    chk("t4b_ch", 32'(hit_ch_o), 1);

    // No hits: timeout (if built).
    watch_en_i = 2'b00;
    result_i = 32'd7;
    do_clear();
    pc_i = 32'h9C;
    step(70);
`ifdef TEST_MON_TIMEOUT_EN
    chk("t5_timeout", 32'(timeout_o), 1);
    chk("t5_cycle", cycle_cnt_o, 64);
    chk("t5_result", result_o, 7);
    chk("t5_done", 32'(done_o), 0);
`else
    step(130);
    chk("t5_no_timeout", 32'(timeout_o), 0);
    chk("t5_cycle", cycle_cnt_o, 200);
`endif

    // 8th entry sampled while cycle count is 64: DONE wins.
    watch_addr_i = {32'h0, 32'hA0};
    watch_en_i = 2'b01;
    result_i = 32'd1;
    do_clear();
    pc_i = 32'h9C; step(50);
    for (int i = 0; i < 8; i++) begin
      pc_i = 32'hA0; step(1);
      if (i < 7) begin
        pc_i = 32'h9C; step(1);
      end
    end
    chk("t6_done", 32'(done_o), 1);
    chk("t6_timeout", 32'(timeout_o), 0);
    chk("t6_pass", 32'(pass_o), 1);

    // Async reset after 3 hits restarts counting.
    do_clear();
    entries(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_first", 32'(first_hit_o), 0);
    chk("t7_cycle", cycle_cnt_o, 0);
    chk("t7_end", end_cycle_o, 0);
    step(1);
    rst_n = 1'b1;
    entries(7);
    chk("t7_seven", 32'(done_o), 0);
    entries(1);
    chk("t7_done", 32'(done_o), 1);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
